// File: rtl/aib_mac_link_seq_pkg.sv
// Shared types and constants for the AIB MAC-side link bring-up sequencer.
package aib_mac_link_pkg;

  localparam int LINK_TMR_W = 16;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    RST_HOLD   = 3'd1,
    WAIT_FS    = 3'd2,
    WAIT_LOCK  = 3'd3,
    WAIT_ALIGN = 3'd4,
    LINK_UP    = 3'd5,
    ERROR      = 3'd6
  } link_state_e;

endpackage

// File: rtl/aib_mac_link_seq_if.sv
// Bring-up handshake bundle between the sequencer (master) and the adapter/far side (slave).
// Handshakes are level-based: each request stays asserted until the matching status is seen.
interface aib_mac_link_seq_if;
  import aib_mac_link_pkg::*;

  logic        link_en;
  logic        i_conf_done;
  logic        fs_mac_rdy;
  logic        tx_transfer_en;
  logic        rx_transfer_en;
  logic        m_rx_align_done;
  logic        ns_adapter_rstn;
  logic        ns_mac_rdy;
  logic        tx_dcc_dll_lock_req;
  logic        rx_dcc_dll_lock_req;
  logic        data_en;
  link_state_e link_state;
  logic [3:0]  retry_cnt;
  logic        err;
  logic        link_drop;

  modport master (
    input  link_en, i_conf_done, fs_mac_rdy, tx_transfer_en, rx_transfer_en, m_rx_align_done,
    output ns_adapter_rstn, ns_mac_rdy, tx_dcc_dll_lock_req, rx_dcc_dll_lock_req, data_en,
           link_state, retry_cnt, err, link_drop
  );

  modport slave (
    output link_en, i_conf_done, fs_mac_rdy, tx_transfer_en, rx_transfer_en, m_rx_align_done,
    input  ns_adapter_rstn, ns_mac_rdy, tx_dcc_dll_lock_req, rx_dcc_dll_lock_req, data_en,
           link_state, retry_cnt, err, link_drop
  );
endinterface

// File: rtl/aib_mac_link_seq_sync2.sv
// Parameterized-width two-flop synchronizer, asynchronously reset to zero.
module aib_mac_sync2 #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] meta;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/aib_mac_link_seq.sv
// MAC-side AIB link bring-up sequencer: reset hold, far-side ready, DCC/DLL lock,
// RX alignment, with timeout/retry and link-drop recovery.
module aib_mac_link_seq
  import aib_mac_link_pkg::*;
#(
  parameter int RSTN_DLY      = 16,
  parameter int FS_TIMEOUT    = 4096,
  parameter int LOCK_TIMEOUT  = 16384,
  parameter int ALIGN_TIMEOUT = 4096,
  parameter int MAX_RETRY     = 3
) (
  input logic                osc_clk,
  input logic                por,
  aib_mac_link_seq_if.master lnk
);
  // Timer holds (cycles in state - 1), so each limit is compared one below its cycle count.
  localparam logic [LINK_TMR_W-1:0] RST_LAST   = LINK_TMR_W'(RSTN_DLY - 1);
  localparam logic [LINK_TMR_W-1:0] FS_LAST    = LINK_TMR_W'(FS_TIMEOUT - 1);
  localparam logic [LINK_TMR_W-1:0] LOCK_LAST  = LINK_TMR_W'(LOCK_TIMEOUT - 1);
  localparam logic [LINK_TMR_W-1:0] ALIGN_LAST = LINK_TMR_W'(ALIGN_TIMEOUT - 1);
  localparam logic [3:0]            RETRY_MAX  = 4'(MAX_RETRY);

  logic [4:0] async_in, sync_out;
  logic conf_s, fs_s, tx_s, rx_s, align_s;

  assign async_in = {lnk.i_conf_done, lnk.fs_mac_rdy, lnk.tx_transfer_en,
                     lnk.rx_transfer_en, lnk.m_rx_align_done};
  assign {conf_s, fs_s, tx_s, rx_s, align_s} = sync_out;

  aib_mac_sync2 #(.W(5)) u_sync (
    .clk (osc_clk),
    .rst (por),
    .d   (async_in),
    .q   (sync_out)
  );

  link_state_e           state, nxt;
  logic [LINK_TMR_W-1:0] tmr;
  logic [3:0]            retry_q, retry_nxt;
  logic                  timeout, drop_nxt;
  logic rstn_q, mac_rdy_q, lock_q, data_en_q, err_q, drop_q;

  always_comb begin
    nxt       = state;
    retry_nxt = retry_q;
    timeout   = 1'b0;
    drop_nxt  = 1'b0;
    if (!lnk.link_en) begin
      nxt = IDLE;
    end else begin
      case (state)
        IDLE:       if (conf_s) nxt = RST_HOLD;
        RST_HOLD:   if (tmr == RST_LAST) nxt = WAIT_FS;
        WAIT_FS:    if (fs_s) nxt = WAIT_LOCK;
                    else if (tmr == FS_LAST) timeout = 1'b1;
        WAIT_LOCK:  if (tx_s && rx_s) nxt = WAIT_ALIGN;
                    else if (tmr == LOCK_LAST) timeout = 1'b1;
        WAIT_ALIGN: if (align_s) nxt = LINK_UP;
                    else if (tmr == ALIGN_LAST) timeout = 1'b1;
        LINK_UP: begin
          if (!fs_s || !tx_s || !rx_s) begin
            nxt       = RST_HOLD;
            drop_nxt  = 1'b1;
            retry_nxt = '0;
          end
        end
        ERROR:      nxt = ERROR;
        default:    nxt = IDLE;
      endcase
    end
    // Exit conditions were tested first, so a timeout only fires when no exit is pending.
    if (timeout) begin
      if (retry_q < RETRY_MAX) begin
        retry_nxt = retry_q + 1'b1;
        nxt       = RST_HOLD;
      end else begin
        nxt = ERROR;
      end
    end
    if (nxt == IDLE || (nxt == LINK_UP && state != LINK_UP)) retry_nxt = '0;
  end

  always_ff @(posedge osc_clk or posedge por) begin
    if (por) begin
      state     <= IDLE;
      tmr       <= '0;
      retry_q   <= '0;
      rstn_q    <= 1'b0;
      mac_rdy_q <= 1'b0;
      lock_q    <= 1'b0;
      data_en_q <= 1'b0;
      err_q     <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state   <= nxt;
      retry_q <= retry_nxt;
      if (nxt != state || nxt == IDLE) tmr <= '0;
      else if (tmr != '1)              tmr <= tmr + 1'b1;
      rstn_q    <= nxt inside {WAIT_FS, WAIT_LOCK, WAIT_ALIGN, LINK_UP};
      mac_rdy_q <= nxt inside {WAIT_FS, WAIT_LOCK, WAIT_ALIGN, LINK_UP};
      lock_q    <= nxt inside {WAIT_LOCK, WAIT_ALIGN, LINK_UP};
      data_en_q <= (nxt == LINK_UP);
      err_q     <= (nxt == ERROR);
      drop_q    <= drop_nxt;
    end
  end

  assign lnk.ns_adapter_rstn     = rstn_q;
  assign lnk.ns_mac_rdy          = mac_rdy_q;
  assign lnk.tx_dcc_dll_lock_req = lock_q;
  assign lnk.rx_dcc_dll_lock_req = lock_q;
  assign lnk.data_en             = data_en_q;
  assign lnk.link_state          = state;
  assign lnk.retry_cnt           = retry_q;
  assign lnk.err                 = err_q;
  assign lnk.link_drop           = drop_q;
endmodule

// File: tb/tb_aib_mac_link_seq.sv
// Bench for aib_mac_link_seq: vector table for bring-up/drop/enable paths, plus
// hand-written sequences for async reset, lock-timeout retries and exit-vs-timeout.
module tb_aib_mac_link_seq;
  import aib_mac_link_pkg::*;

  localparam int RD = 16, FT = 64, LT = 64, AT = 64, MR = 3;

  logic osc_clk = 1'b0;
  logic por     = 1'b1;
  always #5 osc_clk = ~osc_clk;

  aib_mac_link_seq_if lnk();

  aib_mac_link_seq #(
    .RSTN_DLY(RD), .FS_TIMEOUT(FT), .LOCK_TIMEOUT(LT), .ALIGN_TIMEOUT(AT), .MAX_RETRY(MR)
  ) dut (
    .osc_clk (osc_clk),
    .por     (por),
    .lnk     (lnk)
  );

  // inputs are {link_en, conf_done, fs_mac_rdy, tx_en, rx_en, align_done}
  typedef struct {
    logic [5:0]  in;
    int          n;
    link_state_e s;
    logic [3:0]  r;
    logic        d;
  } vec_t;

  vec_t        tbl[32];
  int          checks   = 0;
  int          failures = 0;
  logic [13:0] exp_q[$];
  string       nm_q[$];

  // packed view: {rstn, mac_rdy, tx_lock, rx_lock, data_en, state[2:0], retry[3:0], err, drop}
  function automatic logic [13:0] exp_out(link_state_e s, logic [3:0] r, logic d);
    logic up, lk;
    up = (s == WAIT_FS) || (s == WAIT_LOCK) || (s == WAIT_ALIGN) || (s == LINK_UP);
    lk = (s == WAIT_LOCK) || (s == WAIT_ALIGN) || (s == LINK_UP);
    return {up, up, lk, lk, (s == LINK_UP), 3'(s), r, (s == ERROR), d};
  endfunction

  function automatic logic [13:0] act_out();
    return {lnk.ns_adapter_rstn, lnk.ns_mac_rdy, lnk.tx_dcc_dll_lock_req,
            lnk.rx_dcc_dll_lock_req, lnk.data_en, 3'(lnk.link_state), lnk.retry_cnt,
            lnk.err, lnk.link_drop};
  endfunction

  task automatic drive(input logic [5:0] v);
    {lnk.link_en, lnk.i_conf_done, lnk.fs_mac_rdy, lnk.tx_transfer_en,
     lnk.rx_transfer_en, lnk.m_rx_align_done} = v;
  endtask

  task automatic adv(input int n);
    repeat (n) begin
      @(posedge osc_clk);
      #1;
    end
  endtask

  task automatic push_exp(input string nm, input link_state_e s, input logic [3:0] r,
                          input logic d);
    exp_q.push_back(exp_out(s, r, d));
    nm_q.push_back(nm);
  endtask

  task automatic pop_chk();
    logic [13:0] e, a;
    string nm;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL scoreboard_empty: no expected entry queued");
      return;
    end
    e  = exp_q.pop_front();
    nm = nm_q.pop_front();
    a  = act_out();
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got state=%0d retry=%0d outs=%b, required state=%0d retry=%0d outs=%b",
               nm, a[8:6], a[5:2], a, e[8:6], e[5:2], e);
    end
  endtask

  task automatic step(input string nm, input logic [5:0] v, input int n,
                      input link_state_e s, input logic [3:0] r, input logic d);
    drive(v);
    push_exp(nm, s, r, d);
    adv(n);
    pop_chk();
  endtask

  initial begin
    // nominal bring-up
    tbl[0]  = '{6'b110000,  2, IDLE,       4'd0, 1'b0};
    tbl[1]  = '{6'b110000,  1, RST_HOLD,   4'd0, 1'b0};
    tbl[2]  = '{6'b110000, 15, RST_HOLD,   4'd0, 1'b0};
    tbl[3]  = '{6'b110000,  1, WAIT_FS,    4'd0, 1'b0};
    tbl[4]  = '{6'b110000,  9, WAIT_FS,    4'd0, 1'b0};
    tbl[5]  = '{6'b111000,  2, WAIT_FS,    4'd0, 1'b0};
    tbl[6]  = '{6'b111000,  1, WAIT_LOCK,  4'd0, 1'b0};
    tbl[7]  = '{6'b111000, 49, WAIT_LOCK,  4'd0, 1'b0};
    tbl[8]  = '{6'b111110,  2, WAIT_LOCK,  4'd0, 1'b0};
    tbl[9]  = '{6'b111110,  1, WAIT_ALIGN, 4'd0, 1'b0};
    tbl[10] = '{6'b111110, 19, WAIT_ALIGN, 4'd0, 1'b0};
    tbl[11] = '{6'b111111,  2, WAIT_ALIGN, 4'd0, 1'b0};
    tbl[12] = '{6'b111111,  1, LINK_UP,    4'd0, 1'b0};
    tbl[13] = '{6'b111111,  5, LINK_UP,    4'd0, 1'b0};
    // link drop on rx_transfer_en, then recovery
    tbl[14] = '{6'b111101,  2, LINK_UP,    4'd0, 1'b0};
    tbl[15] = '{6'b111101,  1, RST_HOLD,   4'd0, 1'b1};
    tbl[16] = '{6'b111101,  1, RST_HOLD,   4'd0, 1'b0};
    tbl[17] = '{6'b111111, 14, RST_HOLD,   4'd0, 1'b0};
    tbl[18] = '{6'b111111,  1, WAIT_FS,    4'd0, 1'b0};
    tbl[19] = '{6'b111111,  1, WAIT_LOCK,  4'd0, 1'b0};
    tbl[20] = '{6'b111111,  1, WAIT_ALIGN, 4'd0, 1'b0};
    tbl[21] = '{6'b111111,  1, LINK_UP,    4'd0, 1'b0};
    // link_en drop from LINK_UP and WAIT_FS, then FS timeout
    tbl[22] = '{6'b010000,  1, IDLE,       4'd0, 1'b0};
    tbl[23] = '{6'b110000,  1, RST_HOLD,   4'd0, 1'b0};
    tbl[24] = '{6'b110000, 16, WAIT_FS,    4'd0, 1'b0};
    tbl[25] = '{6'b010000,  1, IDLE,       4'd0, 1'b0};
    tbl[26] = '{6'b110000,  1, RST_HOLD,   4'd0, 1'b0};
    tbl[27] = '{6'b110000, 16, WAIT_FS,    4'd0, 1'b0};
    tbl[28] = '{6'b110000, 63, WAIT_FS,    4'd0, 1'b0};
    tbl[29] = '{6'b110000,  1, RST_HOLD,   4'd1, 1'b0};
    tbl[30] = '{6'b111000, 16, WAIT_FS,    4'd1, 1'b0};
    tbl[31] = '{6'b111000,  1, WAIT_LOCK,  4'd1, 1'b0};

    drive(6'b000000);
    #1;
    push_exp("por_initial", IDLE, 4'd0, 1'b0);
    pop_chk();
    adv(2);
    por = 1'b0;

    for (int i = 0; i < 32; i++) begin
      step($sformatf("vec%0d", i), tbl[i].in, tbl[i].n, tbl[i].s, tbl[i].r, tbl[i].d);
    end

    // por between edges while in WAIT_LOCK
    #2;
    por = 1'b1;
    #1;
    push_exp("por_async", IDLE, 4'd0, 1'b0);
    pop_chk();
    push_exp("por_held", IDLE, 4'd0, 1'b0);
    adv(1);
    pop_chk();
    por = 1'b0;
    step("por_resync", 6'b111000, 2, IDLE, 4'd0, 1'b0);
    step("por_restart", 6'b111000, 1, RST_HOLD, 4'd0, 1'b0);

    // lock timeout: three retries, then ERROR
    for (int r = 0; r <= MR; r++) begin
      step($sformatf("lto_fs_r%0d", r), 6'b111000, RD, WAIT_FS, 4'(r), 1'b0);
      step($sformatf("lto_lock_r%0d", r), 6'b111000, 1, WAIT_LOCK, 4'(r), 1'b0);
      step($sformatf("lto_hold_r%0d", r), 6'b111000, LT - 1, WAIT_LOCK, 4'(r), 1'b0);
      if (r < MR) step($sformatf("lto_retry_r%0d", r), 6'b111000, 1, RST_HOLD, 4'(r + 1), 1'b0);
      else        step("lto_error", 6'b111000, 1, ERROR, 4'(MR), 1'b0);
    end
    step("error_sticky", 6'b111111, 5, ERROR, 4'(MR), 1'b0);
    step("error_exit", 6'b011000, 1, IDLE, 4'd0, 1'b0);

    // alignment arrives on the same cycle the align timeout would fire
    step("sim_rst", 6'b111110, 1, RST_HOLD, 4'd0, 1'b0);
    step("sim_fs", 6'b111110, RD, WAIT_FS, 4'd0, 1'b0);
    step("sim_lock", 6'b111110, 1, WAIT_LOCK, 4'd0, 1'b0);
    step("sim_align", 6'b111110, 1, WAIT_ALIGN, 4'd0, 1'b0);
    step("sim_wait", 6'b111110, AT - 3, WAIT_ALIGN, 4'd0, 1'b0);
    step("sim_sync", 6'b111111, 2, WAIT_ALIGN, 4'd0, 1'b0);
    step("sim_exit_wins", 6'b111111, 1, LINK_UP, 4'd0, 1'b0);

    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_leftover: %0d entries, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/aib_mac_link_seq.md
# aib_mac_link_seq

MAC-side link bring-up sequencer for one AIB channel. Runs on the oscillator clock and drives the near-side adapter reset, MAC-ready, and DCC/DLL lock requests. It waits for the far-side ready, transfer-enable and RX alignment handshakes, then opens the data path. It also provides timeout/retry recovery and link-drop recovery, replacing the ad-hoc bring-up sequencing currently spread across channel benches and top-level glue.

## Interface
Parameters:
- RSTN_DLY, 16: cycles `ns_adapter_rstn` is held low in RST_HOLD (1..65535).
- FS_TIMEOUT, 4096: maximum cycles in WAIT_FS.
- LOCK_TIMEOUT, 16384: maximum cycles in WAIT_LOCK.
- ALIGN_TIMEOUT, 4096: maximum cycles in WAIT_ALIGN.
- MAX_RETRY, 3: timeouts retried before ERROR (0..15).

Ports:
- osc_clk  in  1  sole clock.
- por  in  1  reset; asynchronous, active-high.
- link_en  in  1  local enable, synchronous to osc_clk.
- i_conf_done  in  1  configuration done; async, synchronized internally.
- fs_mac_rdy  in  1  far-side MAC ready; async, synchronized.
- tx_transfer_en  in  1  TX transfer enable from adapter; async, synchronized.
- rx_transfer_en  in  1  RX transfer enable from adapter; async, synchronized.
- m_rx_align_done  in  1  RX word alignment done; async, synchronized.
- ns_adapter_rstn  out  1  near-side adapter reset, active-low.
- ns_mac_rdy  out  1  near-side MAC ready.
- tx_dcc_dll_lock_req  out  1  TX DCC/DLL lock request.
- rx_dcc_dll_lock_req  out  1  RX DCC/DLL lock request.
- data_en  out  1  data path enabled.
- link_state  out  3  current state encoding.
- retry_cnt  out  4  timeouts consumed in the current bring-up.
- err  out  1  sticky; set on entry to ERROR.
- link_drop  out  1  one-cycle pulse on exit from LINK_UP due to a handshake loss.

## Operation
- States: IDLE=0, RST_HOLD=1, WAIT_FS=2, WAIT_LOCK=3, WAIT_ALIGN=4, LINK_UP=5, ERROR=6.
- All async inputs pass through 2-flop synchronizers; `_s` suffix below denotes the synchronized value.
- IDLE: all outputs 0, timer 0, retry_cnt 0, err 0. Go to RST_HOLD when `link_en && i_conf_done_s`.
- RST_HOLD: `ns_adapter_rstn=0`. Go to WAIT_FS after exactly RSTN_DLY cycles in the state.
- WAIT_FS: `ns_adapter_rstn=1`, `ns_mac_rdy=1`. Exit on `fs_mac_rdy_s`.
- WAIT_LOCK: adds both lock_req outputs = 1. Exit when `tx_transfer_en_s && rx_transfer_en_s`.
- WAIT_ALIGN: same outputs as WAIT_LOCK. Exit on `m_rx_align_done_s`.
- LINK_UP: same outputs plus `data_en=1`. On entry, retry_cnt is cleared.
- Timeouts in WAIT_FS, WAIT_LOCK and WAIT_ALIGN:
  - A timeout fires when the state's timer reaches its TIMEOUT value without the exit condition.
  - If retry_cnt < MAX_RETRY: increment retry_cnt and go to RST_HOLD.
  - Otherwise: go to ERROR.
  - If the exit condition and the timeout occur in the same cycle, the exit condition wins.
- LINK_UP drop: if `fs_mac_rdy_s`, `tx_transfer_en_s` or `rx_transfer_en_s` goes low, pulse link_drop, clear retry_cnt, and go to RST_HOLD.
- ERROR: all control outputs 0, err=1. Leave only via `link_en=0`.
- `link_en=0` in any state: go to IDLE next cycle. This has highest synchronous priority.
- Timer: 16-bit, cleared on every state change, saturating. Timeout parameters must be ≤ 65535.

## Timing
- Reset (`por=1`): state IDLE; all outputs 0, including `ns_adapter_rstn=0`. Applies immediately without a clock edge, including mid-operation.
- All outputs are registered and change on the same edge as link_state.
- Async input to state change: 3 edges (2 sync + 1 FSM).
- `link_en` to state change: 1 edge.
- RST_HOLD lasts exactly RSTN_DLY cycles.
- A timeout in state S exits after exactly S_TIMEOUT cycles in S.
- link_drop is high for the single cycle coincident with the first RST_HOLD cycle.
- data_en falls on the same edge as that transition.

## Structure
- Package `aib_mac_link_pkg`:
  - enum `link_state_e` (3-bit, encodings above);
  - constant `LINK_TMR_W = 16`.
- Sub-module `aib_mac_sync2`: parameterized-width 2-flop synchronizer, async active-high reset to 0. Instantiated once with width 5.

## Test plan
- Nominal bring-up (RSTN_DLY=16): conf_done and link_en high; fs_mac_rdy 10 cycles after ns_mac_rdy; transfer_ens 50 cycles after lock_req; align 20 cycles later. Expect: rstn rises exactly 16 cycles into RST_HOLD; data_en=1; link_state=5; retry_cnt=0; err=0.
- Lock timeout (LOCK_TIMEOUT=64, MAX_RETRY=3), transfer_en never asserted. Expect: three RST_HOLD re-entries, each 64 cycles after WAIT_LOCK entry, with retry_cnt 1, 2, 3; then state 6, err=1, outputs 0. Dropping link_en then gives IDLE and err=0.
- Simultaneous events: m_rx_align_done_s rises on exactly the 64th WAIT_ALIGN cycle. Expect LINK_UP, retry_cnt unchanged.
- Link drop: in LINK_UP, drop rx_transfer_en. Expect on the 3rd edge: data_en=0, link_drop single-cycle pulse, state 1. Re-raise the input; the sequence re-completes to LINK_UP.
- Async reset: assert por mid-WAIT_LOCK, between clock edges. Expect outputs 0 with no clock edge; IDLE after release. Bring-up restarts only after 3 edges of conf_done_s.
- Enable drop: link_en=0 in WAIT_FS. Expect IDLE next edge and ns_mac_rdy=0. Re-enabling restarts from RST_HOLD.
